hazard_sequencer: RTL and testbench

//  Pipeline sequencer for the 5-stage RV32I core. Takes decoded control from ID/EX (MemRead,

---
 rtl/hazard_sequencer.sv | 152 +++++++++++++++
 tb/tb_hazard_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_sequencer.sv
// hazard_sequencer: fixed-priority hazard control (memory wait > redirect > load-use) for the RV32I pipeline.
// Define HAZ_PERF_CNT_EN to build the saturating stall/flush performance counters.
module hazard_sequencer #(
  parameter int REG_AW      = 5,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_redirect,
  input  logic              mem_access,
  input  logic              dmem_ready,
  output logic              dmem_req,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              pipe_hold,
  output logic              mem_fault,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0] CNT_LAST = TW'(MEM_TIMEOUT - 1);

  typedef enum logic [0:0] {
    M_IDLE,
    M_WAIT
  } mem_state_t;

  mem_state_t    state_q;
  mem_state_t    state_d;
  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;
  logic          mem_stall;
  logic          load_use;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= M_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Reset abandons any access in flight without raising a fault.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_stall = 1'b0;
    dmem_req  = 1'b0;
    mem_fault = 1'b0;
    if (!reset) begin
      case (state_q)
        M_IDLE: begin
          dmem_req = mem_access;
          if (mem_access && !dmem_ready) begin
            state_d   = M_WAIT;
            cnt_d     = TW'(1);
            mem_stall = 1'b1;
          end
        end
        M_WAIT: begin
          dmem_req  = 1'b1;
          mem_stall = 1'b1;
          if (dmem_ready) begin
            state_d   = M_IDLE;
            cnt_d     = '0;
            mem_stall = 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            // Ready in the same cycle takes precedence over this forced release.
            state_d   = M_IDLE;
            cnt_d     = '0;
            mem_stall = 1'b0;
            dmem_req  = 1'b0;
            mem_fault = 1'b1;
          end else begin
            cnt_d = cnt_q + TW'(1);
          end
        end
        default: begin
          state_d = M_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    pipe_hold  = 1'b0;
    if (reset) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (mem_stall) begin
      pc_en     = 1'b0;
      ifid_en   = 1'b0;
      pipe_hold = 1'b1;
    end else if (ex_redirect) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_en && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      if (!mem_stall && ex_redirect && (flush_q != '1)) begin
        flush_q <= flush_q + CNT_W'(1);
      end
    end
  end

  // Counters read as zero while reset is held, not only after the clearing edge.
  assign stall_cycles = reset ? '0 : stall_q;
  assign flush_count  = reset ? '0 : flush_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// tb_hazard_sequencer: randomized scoreboard bench for hazard_sequencer with a cycle-level reference model.
// Honors HAZ_PERF_CNT_EN the same way as the design.
module tb_hazard_sequencer;

  localparam int REG_AW      = 5;
  localparam int MEM_TIMEOUT = 16;
  localparam int CNT_W       = 6;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

`ifdef HAZ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_mem_read;
  logic              ex_redirect;
  logic              mem_access;
  logic              dmem_ready;
  logic              dmem_req;
  logic              pc_en;
  logic              ifid_en;
  logic              ifid_flush;
  logic              idex_flush;
  logic              pipe_hold;
  logic              mem_fault;
  logic [CNT_W-1:0]  stall_cycles;
  logic [CNT_W-1:0]  flush_count;

  hazard_sequencer #(
    .REG_AW     (REG_AW),
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .ex_redirect (ex_redirect),
    .mem_access  (mem_access),
    .dmem_ready  (dmem_ready),
    .dmem_req    (dmem_req),
    .pc_en       (pc_en),
    .ifid_en     (ifid_en),
    .ifid_flush  (ifid_flush),
    .idex_flush  (idex_flush),
    .pipe_hold   (pipe_hold),
    .mem_fault   (mem_fault),
    .stall_cycles(stall_cycles),
    .flush_count (flush_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int dmem_req;
    int pc_en;
    int ifid_en;
    int ifid_flush;
    int idex_flush;
    int pipe_hold;
    int mem_fault;
    int stall;
    int flush;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  // Reference model: an access is "open" from the cycle it misses; m_age counts its cycles (issue = 1).
  bit m_busy  = 1'b0;
  int m_age   = 0;
  int m_stall = 0;
  int m_flush = 0;

  task automatic checkOutput(input string name, input int act, input int req);
    checks++;
    if (act === req) passes++;
    else $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
  endtask

  task automatic applyStimulus(input bit rst, input int rs1, input int rs2, input bit u1, input bit u2,
                               input int rd, input bit mr, input bit redir, input bit macc, input bit rdy);
    exp_t e;
    bit   stall_now;
    bit   lu;
    @(posedge clk);
    #1;
    reset       = rst;
    id_rs1      = REG_AW'(rs1);
    id_rs2      = REG_AW'(rs2);
    id_use_rs1  = u1;
    id_use_rs2  = u2;
    ex_rd       = REG_AW'(rd);
    ex_mem_read = mr;
    ex_redirect = redir;
    mem_access  = macc;
    dmem_ready  = rdy;
    e = '{default: 0};
    if (rst) begin
      e.ifid_flush = 1;
      e.idex_flush = 1;
      m_busy  = 1'b0;
      m_age   = 0;
      m_stall = 0;
      m_flush = 0;
    end else begin
      stall_now = 1'b0;
      if (!m_busy) begin
        e.dmem_req = int'(macc);
        if (macc && !rdy) begin
          stall_now = 1'b1;
          m_busy    = 1'b1;
          m_age     = 1;
        end
      end else begin
        m_age++;
        e.dmem_req = 1;
        if (rdy) m_busy = 1'b0;
        else if (m_age == MEM_TIMEOUT) begin
          e.mem_fault = 1;
          e.dmem_req  = 0;
          m_busy      = 1'b0;
        end else stall_now = 1'b1;
      end
      lu = mr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
      e.pc_en   = 1;
      e.ifid_en = 1;
      if (stall_now) begin
        e.pc_en     = 0;
        e.ifid_en   = 0;
        e.pipe_hold = 1;
      end else if (redir) begin
        e.ifid_flush = 1;
        e.idex_flush = 1;
      end else if (lu) begin
        e.pc_en      = 0;
        e.ifid_en    = 0;
        e.idex_flush = 1;
      end
      e.stall = PERF ? m_stall : 0;
      e.flush = PERF ? m_flush : 0;
      if (e.pc_en == 0 && m_stall < CNT_MAX) m_stall++;
      if (!stall_now && redir && m_flush < CNT_MAX) m_flush++;
    end
    exp_q.push_back(e);
  endtask

  task automatic idleCycle(input bit macc, input bit rdy);
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, macc, rdy);
  endtask

  // Monitor: every pushed expectation is compared at the falling edge of its cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput("dmem_req",     int'(dmem_req),     e.dmem_req);
      checkOutput("pc_en",        int'(pc_en),        e.pc_en);
      checkOutput("ifid_en",      int'(ifid_en),      e.ifid_en);
      checkOutput("ifid_flush",   int'(ifid_flush),   e.ifid_flush);
      checkOutput("idex_flush",   int'(idex_flush),   e.idex_flush);
      checkOutput("pipe_hold",    int'(pipe_hold),    e.pipe_hold);
      checkOutput("mem_fault",    int'(mem_fault),    e.mem_fault);
      checkOutput("stall_cycles", int'(stall_cycles), e.stall);
      checkOutput("flush_count",  int'(flush_count),  e.flush);
    end
  end

  initial begin
    int  rdy_mode;
    bit  macc;
    bit  rdy;
    reset       = 1'b1;
    id_rs1      = '0;
    id_rs2      = '0;
    id_use_rs1  = 1'b0;
    id_use_rs2  = 1'b0;
    ex_rd       = '0;
    ex_mem_read = 1'b0;
    ex_redirect = 1'b0;
    mem_access  = 1'b0;
    dmem_ready  = 1'b0;

    applyStimulus(1'b1, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    idleCycle(1'b0, 1'b1);

    // Load-use on rs1, then the same with x0 as destination, then redirect over load-use.
    applyStimulus(1'b0, 5, 0, 1'b1, 1'b0, 5, 1'b1, 1'b0, 1'b0, 1'b1);
    idleCycle(1'b0, 1'b1);
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 7, 5, 1'b0, 1'b1, 5, 1'b1, 1'b1, 1'b0, 1'b1);
    idleCycle(1'b0, 1'b1);

    // Memory wait of three cycles, released in the ready cycle.
    for (int i = 0; i < 4; i++) idleCycle(1'b1, i == 3);
    idleCycle(1'b0, 1'b1);

    // Timeout: ready never arrives.
    for (int i = 0; i < MEM_TIMEOUT; i++) idleCycle(1'b1, 1'b0);
    idleCycle(1'b0, 1'b0);

    // Reset while waiting, with a redirect pending during the stall.
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    idleCycle(1'b0, 1'b0);

    rdy_mode = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 29) == 0) rdy_mode = $urandom_range(0, 2);
      case (rdy_mode)
        0:       rdy = ($urandom_range(0, 3) != 0);
        1:       rdy = ($urandom_range(0, 7) == 0);
        default: rdy = 1'b0;
      endcase
      macc = m_busy ? 1'b1 : ($urandom_range(0, 2) == 0);
      applyStimulus($urandom_range(0, 99) == 0,
                    $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 3), $urandom_range(0, 1) == 1,
                    $urandom_range(0, 5) == 0, macc, rdy);
    end

    idleCycle(1'b0, 1'b1);
    @(negedge clk);
    #1;
    checkOutput("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
